turn_scheduler: RTL and testbench

TURN_SCHEDULER -- requirements
Module: turn_scheduler

---
 rtl/turn_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_turn_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_scheduler.sv
// turn_scheduler: alternating-turn controller for a 5x5 two-sided board game.
//
// The player picks a cell through the button selector (sel_enable) within a
// TIMEOUT_CYCLES window, or forfeits the turn. The PC picks a cell when
// pc_enable is high and has no time limit. Each accepted cell goes to the
// shared attack unit through a held atk_req handshake. A hit takes one life
// from the attacked side. Reaching zero lives ends the game.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       one-cycle pulse, starts a game from IDLE/GAME_OVER
//   player_sel_valid/row/col    player cell choice
//   pc_sel_valid/row/col        PC cell choice
//   sel_enable, pc_enable       selector enables (PLAYER_SEL / PC_SEL only)
//   atk_req/row/col/target      attack request; target 0 = PC board, 1 = player board
//   atk_done, atk_hit           attack completion and result
//   player_turn                 1 while it is the player's turn
//   timeout                     one-cycle pulse when the player window expires
//   player_life, pc_life        remaining lives
//   game_over, player_won       game finished / winner flag
module turn_scheduler #(
    parameter int TIMEOUT_CYCLES = 750000000,
    parameter int LIFE_INIT      = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       player_sel_valid,
    input  logic [2:0] player_row,
    input  logic [2:0] player_col,
    input  logic       pc_sel_valid,
    input  logic [2:0] pc_row,
    input  logic [2:0] pc_col,
    input  logic       atk_done,
    input  logic       atk_hit,
    output logic       sel_enable,
    output logic       pc_enable,
    output logic       atk_req,
    output logic [2:0] atk_row,
    output logic [2:0] atk_col,
    output logic       atk_target,
    output logic       player_turn,
    output logic       timeout,
    output logic [4:0] player_life,
    output logic [4:0] pc_life,
    output logic       game_over,
    output logic       player_won
);

    localparam int              TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]      LIFE_START = 5'(LIFE_INIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAYER_SEL,
        S_PC_SEL,
        S_ATTACK,
        S_UPDATE,
        S_GAME_OVER
    } state_t;

    // Row-major bit position of a cell in a 25-bit shot map.
    function automatic logic [4:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
        return 5'(row) * 5'd5 + 5'(col);
    endfunction

    // A cell is legal when it is on the board and not yet shot by this attacker.
    function automatic logic cell_legal(input logic [24:0] map, input logic [2:0] row,
                                        input logic [2:0] col);
        if (row > 3'd4 || col > 3'd4) return 1'b0;
        return !map[cell_idx(row, col)];
    endfunction

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [24:0]   player_map_q, player_map_d;   // cells the player has fired at
    logic [24:0]   pc_map_q, pc_map_d;           // cells the PC has fired at
    logic [2:0]    atk_row_q, atk_row_d;
    logic [2:0]    atk_col_q, atk_col_d;
    logic          atk_target_q, atk_target_d;
    logic          hit_q, hit_d;
    logic [4:0]    player_life_q, player_life_d;
    logic [4:0]    pc_life_q, pc_life_d;
    logic          player_turn_q, player_turn_d;
    logic          timeout_q, timeout_d;
    logic          player_won_q, player_won_d;
    logic          sel_enable_q, sel_enable_d;
    logic          pc_enable_q, pc_enable_d;
    logic          atk_req_q, atk_req_d;
    logic          game_over_q, game_over_d;
    logic [4:0]    tgt_life;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        player_map_d  = player_map_q;
        pc_map_d      = pc_map_q;
        atk_row_d     = atk_row_q;
        atk_col_d     = atk_col_q;
        atk_target_d  = atk_target_q;
        hit_d         = hit_q;
        player_life_d = player_life_q;
        pc_life_d     = pc_life_q;
        player_turn_d = player_turn_q;
        player_won_d  = player_won_q;
        timeout_d     = 1'b0;
        tgt_life      = '0;

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start) begin
                    state_d       = S_PLAYER_SEL;
                    player_life_d = LIFE_START;
                    pc_life_d     = LIFE_START;
                    player_map_d  = '0;
                    pc_map_d      = '0;
                    timer_d       = '0;
                    player_turn_d = 1'b1;
                    player_won_d  = 1'b0;
                end
            end
            S_PLAYER_SEL: begin
                // A legal choice takes priority over window expiry in the same cycle.
                if (player_sel_valid && cell_legal(player_map_q, player_row, player_col)) begin
                    state_d      = S_ATTACK;
                    atk_row_d    = player_row;
                    atk_col_d    = player_col;
                    atk_target_d = 1'b0;
                    timer_d      = '0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d       = S_PC_SEL;
                    timeout_d     = 1'b1;
                    player_turn_d = 1'b0;
                    timer_d       = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_PC_SEL: begin
                if (pc_sel_valid && cell_legal(pc_map_q, pc_row, pc_col)) begin
                    state_d      = S_ATTACK;
                    atk_row_d    = pc_row;
                    atk_col_d    = pc_col;
                    atk_target_d = 1'b1;
                end
            end
            S_ATTACK: begin
                if (atk_done) begin
                    hit_d   = atk_hit;
                    state_d = S_UPDATE;
                    if (!atk_target_q) player_map_d[cell_idx(atk_row_q, atk_col_q)] = 1'b1;
                    else               pc_map_d[cell_idx(atk_row_q, atk_col_q)]     = 1'b1;
                end
            end
            S_UPDATE: begin
                if (!atk_target_q) begin
                    if (hit_q && pc_life_q != '0) pc_life_d = pc_life_q - 5'd1;
                    tgt_life = pc_life_d;
                end else begin
                    if (hit_q && player_life_q != '0) player_life_d = player_life_q - 5'd1;
                    tgt_life = player_life_d;
                end
                if (tgt_life == '0) begin
                    state_d      = S_GAME_OVER;
                    player_won_d = !atk_target_q;
                end else begin
                    // The side that was attacked moves next.
                    player_turn_d = atk_target_q;
                    state_d       = atk_target_q ? S_PLAYER_SEL : S_PC_SEL;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Decoded from the next state so these outputs are registered yet aligned with state_q.
        sel_enable_d = (state_d == S_PLAYER_SEL);
        pc_enable_d  = (state_d == S_PC_SEL);
        atk_req_d    = (state_d == S_ATTACK);
        game_over_d  = (state_d == S_GAME_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            player_map_q  <= '0;
            pc_map_q      <= '0;
            atk_row_q     <= '0;
            atk_col_q     <= '0;
            atk_target_q  <= 1'b0;
            hit_q         <= 1'b0;
            player_life_q <= LIFE_START;
            pc_life_q     <= LIFE_START;
            player_turn_q <= 1'b1;
            timeout_q     <= 1'b0;
            player_won_q  <= 1'b0;
            sel_enable_q  <= 1'b0;
            pc_enable_q   <= 1'b0;
            atk_req_q     <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            player_map_q  <= player_map_d;
            pc_map_q      <= pc_map_d;
            atk_row_q     <= atk_row_d;
            atk_col_q     <= atk_col_d;
            atk_target_q  <= atk_target_d;
            hit_q         <= hit_d;
            player_life_q <= player_life_d;
            pc_life_q     <= pc_life_d;
            player_turn_q <= player_turn_d;
            timeout_q     <= timeout_d;
            player_won_q  <= player_won_d;
            sel_enable_q  <= sel_enable_d;
            pc_enable_q   <= pc_enable_d;
            atk_req_q     <= atk_req_d;
            game_over_q   <= game_over_d;
        end
    end

    assign sel_enable  = sel_enable_q;
    assign pc_enable   = pc_enable_q;
    assign atk_req     = atk_req_q;
    assign atk_row     = atk_row_q;
    assign atk_col     = atk_col_q;
    assign atk_target  = atk_target_q;
    assign player_turn = player_turn_q;
    assign timeout     = timeout_q;
    assign player_life = player_life_q;
    assign pc_life     = pc_life_q;
    assign game_over   = game_over_q;
    assign player_won  = player_won_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Testbench for turn_scheduler (TIMEOUT_CYCLES=16, LIFE_INIT=15).
// Expected values come from a game-level model: per-side lives, per-side sets
// of cells already fired at, whose turn it is and whether the game is over.
module tb_turn_scheduler;

    localparam int TO = 16;
    localparam int LI = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       player_sel_valid = 1'b0;
    logic [2:0] player_row = '0;
    logic [2:0] player_col = '0;
    logic       pc_sel_valid = 1'b0;
    logic [2:0] pc_row = '0;
    logic [2:0] pc_col = '0;
    logic       atk_done = 1'b0;
    logic       atk_hit = 1'b0;
    logic       sel_enable, pc_enable, atk_req, atk_target, player_turn, timeout;
    logic       game_over, player_won;
    logic [2:0] atk_row, atk_col;
    logic [4:0] player_life, pc_life;

    turn_scheduler #(.TIMEOUT_CYCLES(TO), .LIFE_INIT(LI)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .player_sel_valid(player_sel_valid), .player_row(player_row), .player_col(player_col),
        .pc_sel_valid(pc_sel_valid), .pc_row(pc_row), .pc_col(pc_col),
        .atk_done(atk_done), .atk_hit(atk_hit),
        .sel_enable(sel_enable), .pc_enable(pc_enable),
        .atk_req(atk_req), .atk_row(atk_row), .atk_col(atk_col), .atk_target(atk_target),
        .player_turn(player_turn), .timeout(timeout),
        .player_life(player_life), .pc_life(pc_life),
        .game_over(game_over), .player_won(player_won)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Game-level reference model.
    int m_plife, m_clife;
    bit m_pshot[25];   // cells the player has fired at
    bit m_cshot[25];   // cells the PC has fired at
    bit m_turn;        // 1 = player's turn
    bit m_over;
    int pk;            // next cell for scripted PC misses
    bit acc_v;

    typedef struct {
        logic [2:0] r;
        logic [2:0] c;
        bit         hit;
        bit         acc;
        logic [4:0] pc_life;
    } vec_t;
    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_ctl"}, {sel_enable, pc_enable, atk_req, timeout, game_over, player_won}, 6'b0);
        chk({nm, "_turn"}, player_turn, 1'b1);
        chk({nm, "_lives"}, {player_life, pc_life}, {5'(LI), 5'(LI)});
    endtask

    task automatic new_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_plife = LI;
        m_clife = LI;
        foreach (m_pshot[i]) begin
            m_pshot[i] = 1'b0;
            m_cshot[i] = 1'b0;
        end
        m_turn = 1'b1;
        m_over = 1'b0;
        pk = 0;
        chk("ng_sel", sel_enable, 1'b1);
        chk("ng_lives", {player_life, pc_life}, {5'(LI), 5'(LI)});
        chk("ng_over", {game_over, player_won, player_turn}, 3'b001);
    endtask

    // One selection attempt by either side, driven through to the life update when accepted.
    task automatic attack(input bit pc, input logic [2:0] r, input logic [2:0] c, input bit hit,
                          input int dly, output bit acc);
        bit legal;
        int idx;
        legal = (r <= 3'd4) && (c <= 3'd4);
        idx = 0;
        if (legal) begin
            idx = int'(r) * 5 + int'(c);
            legal = pc ? !m_cshot[idx] : !m_pshot[idx];
        end
        if (pc) begin pc_row = r; pc_col = c; pc_sel_valid = 1'b1; end
        else    begin player_row = r; player_col = c; player_sel_valid = 1'b1; end
        tick();
        pc_sel_valid = 1'b0;
        player_sel_valid = 1'b0;
        acc = atk_req;
        chk("accept", atk_req, legal);
        chk("no_timeout", timeout, 1'b0);
        if (!legal) begin
            chk("held_sel", pc ? pc_enable : sel_enable, 1'b1);
            return;
        end
        chk("atk_rct", {atk_row, atk_col, atk_target}, {r, c, pc});
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("hold_req", atk_req, 1'b1);
            chk("hold_rct", {atk_row, atk_col, atk_target}, {r, c, pc});
            chk("hold_to", timeout, 1'b0);
        end
        atk_done = 1'b1;
        atk_hit = hit;
        tick();
        atk_done = 1'b0;
        atk_hit = 1'b0;
        chk("req_drop", atk_req, 1'b0);
        tick();
        if (pc) begin
            m_cshot[idx] = 1'b1;
            if (hit && m_plife > 0) m_plife--;
        end else begin
            m_pshot[idx] = 1'b1;
            if (hit && m_clife > 0) m_clife--;
        end
        chk("lives", {player_life, pc_life}, {5'(m_plife), 5'(m_clife)});
        if ((pc ? m_plife : m_clife) == 0) begin
            m_over = 1'b1;
            chk("go_flags", {game_over, player_won}, {1'b1, !pc});
            chk("go_en", {sel_enable, pc_enable, atk_req}, 3'b0);
        end else begin
            m_turn = pc;
            chk("turn", player_turn, m_turn);
            chk("next_en", {sel_enable, pc_enable, game_over}, {m_turn, !m_turn, 1'b0});
        end
    endtask

    task automatic pc_move();
        attack(1'b1, 3'(pk / 5), 3'(pk % 5), 1'b0, 0, acc_v);
        pk++;
    endtask

    // Must start on the first cycle of a player window.
    task automatic do_timeout();
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            chk("win_open", {sel_enable, timeout}, 2'b10);
        end
        tick();
        chk("timeout_pulse", {timeout, pc_enable, sel_enable, atk_req}, 4'b1100);
        chk("timeout_lives", {player_life, pc_life}, {5'(m_plife), 5'(m_clife)});
        chk("timeout_turn", player_turn, 1'b0);
        m_turn = 1'b0;
    endtask

    task automatic pick_free(input bit pc, output int idx, output int nfree);
        int q[$];
        for (int i = 0; i < 25; i++)
            if (!(pc ? m_cshot[i] : m_pshot[i])) q.push_back(i);
        nfree = q.size();
        idx = (nfree == 0) ? 0 : q[$urandom_range(nfree - 1)];
    endtask

    task automatic rand_turn(input bit pc);
        int idx, nf;
        bit hit;
        bit acc;
        acc = 1'b0;
        if (pc && ($urandom % 3 == 0)) begin
            // Stray completion and start pulses while waiting for the PC must do nothing.
            atk_done = 1'b1; atk_hit = 1'b1; start = 1'b1;
            tick();
            atk_done = 1'b0; atk_hit = 1'b0; start = 1'b0;
            chk("stray_en", {pc_enable, atk_req}, 2'b10);
            chk("stray_life", {player_life, pc_life}, {5'(m_plife), 5'(m_clife)});
        end
        if ($urandom % 4 == 0)
            attack(pc, 3'($urandom % 8), 3'($urandom % 8), 1'b1, $urandom % 4, acc);
        if (!acc && !m_over) begin
            pick_free(pc, idx, nf);
            // Force a hit once remaining free cells only just cover remaining lives.
            hit = ((pc ? m_plife : m_clife) >= nf) || ($urandom % 4 != 0);
            attack(pc, 3'(idx / 5), 3'(idx % 5), hit, $urandom % 4, acc);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3'd2, 3'd3, 1'b1, 1'b1, 5'd14};
        tbl[1] = '{3'd2, 3'd3, 1'b1, 1'b0, 5'd14};
        tbl[2] = '{3'd5, 3'd0, 1'b1, 1'b0, 5'd14};
        tbl[3] = '{3'd1, 3'd6, 1'b1, 1'b0, 5'd14};
        tbl[4] = '{3'd1, 3'd1, 1'b0, 1'b1, 5'd14};
        tbl[5] = '{3'd4, 3'd4, 1'b1, 1'b1, 5'd13};
        tbl[6] = '{3'd4, 3'd4, 1'b1, 1'b0, 5'd13};
        tbl[7] = '{3'd0, 3'd0, 1'b1, 1'b1, 5'd12};

        // Reset state, during and after reset.
        tick();
        tick();
        chk_reset_vals("rst_hold");
        rst_n = 1'b1;
        tick();
        chk_reset_vals("rst_rel");

        // Table: accepted, repeated and off-board player selections.
        new_game();
        foreach (tbl[i]) begin
            attack(1'b0, tbl[i].r, tbl[i].c, tbl[i].hit, 0, acc_v);
            chk("tbl_acc", acc_v, tbl[i].acc);
            chk("tbl_pclife", pc_life, tbl[i].pc_life);
            if (acc_v) pc_move();
        end

        // Player window expiry, then a legal choice on the expiry cycle held for 100 cycles.
        do_timeout();
        pc_move();
        for (int i = 0; i < TO - 1; i++) tick();
        attack(1'b0, 3'd3, 3'd3, 1'b0, 100, acc_v);
        pc_move();

        // Asynchronous reset in the middle of an attack.
        player_row = 3'd1; player_col = 3'd2; player_sel_valid = 1'b1;
        tick();
        player_sel_valid = 1'b0;
        chk("mid_req", atk_req, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_req", atk_req, 1'b0);
        chk_reset_vals("rst_async");
        tick();
        rst_n = 1'b1;
        atk_done = 1'b1; atk_hit = 1'b1;
        tick();
        atk_done = 1'b0; atk_hit = 1'b0;
        chk_reset_vals("late_done");

        // Fifteen player hits against PC misses, then a fresh game.
        new_game();
        for (int k = 0; k < 15; k++) begin
            attack(1'b0, 3'(k / 5), 3'(k % 5), 1'b1, 0, acc_v);
            if (k < 14) pc_move();
        end
        chk("win_pclife", pc_life, 5'd0);
        player_row = 3'd4; player_col = 3'd4; player_sel_valid = 1'b1; atk_done = 1'b1;
        tick();
        player_sel_valid = 1'b0; atk_done = 1'b0;
        chk("go_ignore", {game_over, player_won, sel_enable, atk_req}, 4'b1100);
        new_game();
        attack(1'b0, 3'd0, 3'd0, 1'b1, 0, acc_v);

        // Randomized play until several games have finished.
        for (int g = 0; g < 3; g++) begin
            int turns = 0;
            while (!m_over && turns < 200) begin
                if (m_turn && !m_over && ($urandom % 8 == 0)) do_timeout();
                else rand_turn(!m_turn);
                turns++;
            end
            chk("rand_over", game_over, 1'b1);
            new_game();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
